// File: rtl/dram_retention_array_if.sv
// Command/response bus between the memory controller model and the DRAM retention array.
interface dram_retention_array_if #(
  parameter int unsigned ROW_AW = 4,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ROW_AW-1:0] cmd_row;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fail;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_fail
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_fail
  );
endinterface

// File: rtl/dram_retention_array.sv
// Behavioural DRAM cell array: per-row data plus a stored-charge level that leaks at a
// temperature-scaled rate, with a READ/WRITE/REFRESH sense-and-restore command FSM.
module dram_retention_array #(
  parameter int unsigned N_ROWS      = 16,
  parameter int unsigned ROW_AW      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CHARGE_W    = 8,
  parameter int unsigned SENSE_TH    = 128,
  parameter int unsigned BASE_PERIOD = 1024,
  parameter int unsigned TEMP_W      = 4,
  parameter int unsigned PER_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TEMP_W-1:0]      temp_code,
  dram_retention_array_if.slave  bus,
  output logic [15:0]            fail_count,
  input  logic [ROW_AW-1:0]      dbg_row,
  output logic [CHARGE_W-1:0]    dbg_charge
);

  localparam int unsigned          N_SLOT  = 2 ** ROW_AW;
  localparam logic [CHARGE_W-1:0]  QMAX    = '1;
  localparam logic [CHARGE_W-1:0]  SENSE_Q = CHARGE_W'(SENSE_TH);
  localparam logic [PER_W-1:0]     BASE_Q  = PER_W'(BASE_PERIOD);
  localparam logic [1:0]           OP_NOP   = 2'b00;
  localparam logic [1:0]           OP_READ  = 2'b01;
  localparam logic [1:0]           OP_WRITE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACT, S_SENSE} state_t;

  state_t              state;
  logic [1:0]          lat_op;
  logic [ROW_AW-1:0]   lat_row;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_ok;
  logic [CHARGE_W-1:0] snap_q;
  logic [PER_W-1:0]    tick_cnt;

  logic [CHARGE_W-1:0] charge_q [N_ROWS];
  logic [DATA_W-1:0]   data_q   [N_ROWS];

  // Address-space views; slots beyond N_ROWS read as empty and invalid.
  logic [CHARGE_W-1:0] charge_view [N_SLOT];
  logic [DATA_W-1:0]   data_view   [N_SLOT];
  logic                row_ok      [N_SLOT];

  for (genvar s = 0; s < N_SLOT; s++) begin : g_view
    if (s < N_ROWS) begin : g_real
      assign charge_view[s] = charge_q[s];
      assign data_view[s]   = data_q[s];
      assign row_ok[s]      = 1'b1;
    end else begin : g_empty
      assign charge_view[s] = '0;
      assign data_view[s]   = '0;
      assign row_ok[s]      = 1'b0;
    end
  end

  assign dbg_charge = charge_view[dbg_row];

  // Decay period halves per temperature step, floored at one cycle.
  logic [PER_W-1:0] shifted_c;
  logic [PER_W-1:0] period_m1_c;
  logic             tick_c;

  always_comb begin
    shifted_c = BASE_Q >> temp_code;
    if (shifted_c == '0) begin
      shifted_c = PER_W'(1);
    end
    period_m1_c = shifted_c - PER_W'(1);
    tick_c      = (tick_cnt >= period_m1_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + PER_W'(1);
    end
  end

  logic sense_c;
  logic snap_low_c;
  logic sense_fail_c;

  always_comb begin
    sense_c      = (state == S_SENSE) && lat_ok;
    snap_low_c   = (snap_q < SENSE_Q);
    sense_fail_c = (lat_op != OP_WRITE) && snap_low_c;
  end

  // Cell array: restore on sense takes priority over a same-cycle decay tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ROWS; i++) begin
        charge_q[i] <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_ROWS; i++) begin
        if (sense_c && (lat_row == ROW_AW'(i))) begin
          charge_q[i] <= QMAX;
          if (lat_op == OP_WRITE) begin
            data_q[i] <= lat_wdata;
          end else if (snap_low_c) begin
            data_q[i] <= '0;
          end
        end else if (tick_c && (charge_q[i] != '0)) begin
          charge_q[i] <= charge_q[i] - CHARGE_W'(1);
        end
      end
    end
  end

  // Command FSM: IDLE -> ACT (snapshot) -> SENSE (restore, respond) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.cmd_ready <= 1'b0;
      lat_op        <= OP_NOP;
      lat_row       <= '0;
      lat_wdata     <= '0;
      lat_ok        <= 1'b0;
      snap_q        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_fail  <= 1'b0;
      fail_count    <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready && (bus.cmd_op != OP_NOP)) begin
            lat_op        <= bus.cmd_op;
            lat_row       <= bus.cmd_row;
            lat_wdata     <= bus.cmd_wdata;
            lat_ok        <= row_ok[bus.cmd_row];
            bus.cmd_ready <= 1'b0;
            state         <= S_ACT;
          end
        end
        S_ACT: begin
          snap_q <= charge_view[lat_row];
          state  <= S_SENSE;
        end
        S_SENSE: begin
          state         <= S_IDLE;
          bus.cmd_ready <= 1'b1;
          bus.rsp_valid <= 1'b1;
          bus.rsp_fail  <= !lat_ok || sense_fail_c;
          if (lat_ok && (lat_op == OP_READ) && !snap_low_c) begin
            bus.rsp_rdata <= data_view[lat_row];
          end else begin
            bus.rsp_rdata <= '0;
          end
          if (lat_ok && sense_fail_c && (fail_count != 16'hFFFF)) begin
            fail_count <= fail_count + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_retention_array.sv
// Directed plus randomized bench for dram_retention_array against a row-level charge/data model.
module tb_dram_retention_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  temp_code;
  logic [3:0]  dbg_row;
  logic [7:0]  dbg_charge;
  logic [15:0] fail_count;

  always #5 clk = ~clk;

  dram_retention_array_if #(.ROW_AW(4), .DATA_W(8)) bus ();

  dram_retention_array dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temp_code  (temp_code),
    .bus        (bus),
    .fail_count (fail_count),
    .dbg_row    (dbg_row),
    .dbg_charge (dbg_charge)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: charge levels, data and failure count per row.
  int m_cnt;
  int m_charge [16];
  int m_data   [16];
  int m_fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int period_of(input int t);
    int p;
    p = (t >= 16) ? 0 : (1024 >> t);
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_fails = 0;
    for (int r = 0; r < 16; r++) begin
      m_charge[r] = 0;
      m_data[r]   = 0;
    end
  endtask

  // One clock: decay on tick, restore of the sensed row wins over decay.
  task automatic step(input bit restore, input int row);
    bit tick;
    tick = (m_cnt >= period_of(int'(temp_code)) - 1);
    for (int r = 0; r < 16; r++) begin
      if (restore && r == row) m_charge[r] = 255;
      else if (tick && m_charge[r] > 0) m_charge[r] = m_charge[r] - 1;
    end
    m_cnt = tick ? 0 : m_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic dbg_chk(input string tag, input int row);
    dbg_row = 4'(row);
    #1;
    chk(tag, 32'(dbg_charge), 32'(m_charge[row]));
  endtask

  task automatic do_cmd(input logic [1:0] op, input int row, input logic [7:0] wd,
                        output logic [7:0] rd, output logic fl);
    int snap;
    bit efail;
    int erd;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_row   = 4'(row);
    bus.cmd_wdata = wd;
    step(1'b0, 0);
    bus.cmd_valid = 1'b0;
    bus.cmd_row   = 4'($urandom);
    bus.cmd_wdata = 8'($urandom);
    rd = 8'h00;
    fl = 1'b0;
    if (op == 2'b00) begin
      chk("nop_ready", 32'(bus.cmd_ready), 32'd1);
      step(1'b0, 0);
      chk("nop_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end else begin
      snap = m_charge[row];
      chk("busy_not_ready", 32'(bus.cmd_ready), 32'd0);
      step(1'b0, 0);
      chk("no_early_rsp", 32'(bus.rsp_valid), 32'd0);
      efail = (op != 2'b10) && (snap < 128);
      erd   = (op == 2'b01 && !efail) ? m_data[row] : 0;
      if (op == 2'b10) m_data[row] = int'(wd);
      else if (efail) m_data[row] = 0;
      if (efail && m_fails < 65535) m_fails++;
      step(1'b1, row);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(erd));
      chk("rsp_fail", 32'(bus.rsp_fail), 32'(efail));
      chk("fail_count", 32'(fail_count), 32'(m_fails));
      rd = bus.rsp_rdata;
      fl = bus.rsp_fail;
      dbg_chk("restored_charge", row);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       fl;
    int         c1;
    int         gap;
    int         temps [3];
    int         exp_q [3];

    temp_code     = 4'd0;
    dbg_row       = 4'd0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_row   = 4'd0;
    bus.cmd_wdata = 8'd0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_rsp_fail", 32'(bus.rsp_fail), 32'd0);
    chk("rst_fail_count", 32'(fail_count), 32'd0);
    for (int r = 0; r < 16; r++) dbg_chk("rst_charge", r);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 0);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // Write then read back
    do_cmd(2'b10, 3, 8'hA5, rd, fl);
    do_cmd(2'b01, 3, 8'h00, rd, fl);
    chk("wr_rd_data", 32'(rd), 32'hA5);
    chk("wr_rd_fail", 32'(fl), 32'd0);

    // Threshold decay at period 64
    temp_code = 4'd4;
    do_cmd(2'b10, 5, 8'h3C, rd, fl);
    idle(7680);
    do_cmd(2'b01, 5, 8'h00, rd, fl);
    chk("decay120_data", 32'(rd), 32'h3C);
    chk("decay120_fail", 32'(fl), 32'd0);
    do_cmd(2'b10, 5, 8'h3C, rd, fl);
    idle(8320);
    do_cmd(2'b01, 5, 8'h00, rd, fl);
    chk("decay130_data", 32'(rd), 32'h00);
    chk("decay130_fail", 32'(fl), 32'd1);
    chk("decay130_count", 32'(fail_count), 32'd1);

    // Temperature scaling over a fixed 4096-cycle interval
    temps = '{0, 3, 10};
    exp_q = '{251, 223, 0};
    for (int k = 0; k < 3; k++) begin
      temp_code = 4'(temps[k]);
      do_cmd(2'b10, 6, 8'h77, rd, fl);
      idle(4096);
      dbg_chk("temp_model", 6);
      chk("temp_const", 32'(dbg_charge), 32'(exp_q[k]));
    end

    // Periodic refresh keeps data alive
    temp_code = 4'd4;
    do_cmd(2'b10, 2, 8'h5A, rd, fl);
    for (int k = 0; k < 6; k++) begin
      idle(6396);
      do_cmd(2'b11, 2, 8'h00, rd, fl);
      chk("refresh_fail", 32'(fl), 32'd0);
    end
    do_cmd(2'b01, 2, 8'h00, rd, fl);
    chk("refresh_data", 32'(rd), 32'h5A);

    // Unwritten row reads as failed
    do_cmd(2'b01, 9, 8'h00, rd, fl);
    chk("unwritten_fail", 32'(fl), 32'd1);

    // Decay tick aligned to the SENSE cycle of a write
    temp_code = 4'd0;
    do_cmd(2'b10, 1, 8'h11, rd, fl);
    for (int i = 0; i < 2100 && m_cnt != 1021; i++) step(1'b0, 0);
    c1 = m_charge[1];
    do_cmd(2'b10, 0, 8'h22, rd, fl);
    chk("coll_row0", 32'(dbg_charge), 32'd255);
    dbg_row = 4'd1;
    #1;
    chk("coll_row1", 32'(dbg_charge), 32'(c1 - 1));

    // Reset during ACT of a read
    chk("pre_rst_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_row   = 4'd3;
    step(1'b0, 0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("midrst_count", 32'(fail_count), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    for (int r = 0; r < 16; r++) dbg_chk("midrst_charge", r);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 0);
    chk("midrst_ready_after", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0);
      chk("midrst_no_late_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // Randomized commands, temperatures and idle gaps
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) temp_code = 4'($urandom_range(0, 6));
      do_cmd(2'($urandom), int'($urandom_range(0, 15)), 8'($urandom), rd, fl);
      gap = int'($urandom_range(0, 150));
      if (gap > 0) begin
        step(1'b0, 0);
        chk("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
        idle(gap - 1);
      end
      dbg_chk("rand_charge", int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
